// File: rtl/uart_tx_sequencer_if.sv
// Peripheral bus bundle shared by the UART transmit sequencer.
// The master drives strobes, address and write data. The slave returns
// read data combinationally in the same cycle.
interface uart_tx_sequencer_if;
  logic        bus_rd;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    output bus_rd,
    output bus_wr,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata
  );

  modport slave (
    input  bus_rd,
    input  bus_wr,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata
  );
endinterface

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: buffers bytes from a hardware source and writes them
// to the UART transmit register. It uses the peripheral bus only in cycles
// the CPU leaves idle, so the CPU always wins the shared bus.
// Optional feature: define UART_TXSEQ_IRQ_EN to add the tx_done_irq pulse
// output, raised once the last queued byte has left the UART.
module uart_tx_sequencer #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] TXD_ADDR   = 32'h4000_0018,
  parameter logic [31:0] CON_ADDR   = 32'h4000_0020,
  parameter int          SETTLE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_rd,
  input  logic                     cpu_wr,
  input  logic [31:0]              cpu_addr,
  input  logic [31:0]              cpu_wdata,
  output logic [31:0]              cpu_rdata,
  uart_tx_sequencer_if.master      bus,
  input  logic                     s_valid,
  input  logic [7:0]               s_data,
  output logic                     s_ready,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef UART_TXSEQ_IRQ_EN
  ,
  output logic                     tx_done_irq
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (SETTLE_MAX > 1) ? $clog2(SETTLE_MAX) : 1;
  localparam logic [AW:0]   DEPTH_C     = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_MAX - 1);

  typedef enum logic [2:0] {IDLE, POLL, WRITE, SETTLE, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] settle_cnt, settle_nxt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic          cpu_act, grant, push, pop;
  logic          seq_rd, seq_wr;
  logic [31:0]   seq_addr, seq_wdata;
  logic          uart_busy, uart_en;

  assign cpu_act   = cpu_rd | cpu_wr;
  assign grant     = ~cpu_act;
  assign uart_busy = bus.bus_rdata[4];
  assign uart_en   = bus.bus_rdata[0];

  assign s_ready    = (count < DEPTH_C);
  assign push       = s_valid & s_ready;
  // Pop only when the TXD write actually reaches the bus.
  assign pop        = (state == WRITE) & grant;
  assign fifo_count = count;
  assign busy       = (count != '0) | (state != IDLE);
  assign cpu_rdata  = cpu_rd ? bus.bus_rdata : 32'h0;

  // FIFO storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM state and settle counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  // Next-state and sequencer bus request; nothing advances while the CPU owns the bus.
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    seq_rd     = 1'b0;
    seq_wr     = 1'b0;
    seq_addr   = 32'h0;
    seq_wdata  = 32'h0;
    case (state)
      IDLE: begin
        if (grant && count != '0) state_nxt = POLL;
      end
      POLL: begin
        seq_rd   = 1'b1;
        seq_addr = CON_ADDR;
        if (grant && !uart_busy && uart_en) state_nxt = WRITE;
      end
      WRITE: begin
        seq_wr    = 1'b1;
        seq_addr  = TXD_ADDR;
        seq_wdata = {24'h0, mem[rd_ptr]};
        if (grant) begin
          settle_nxt = '0;
          state_nxt  = SETTLE;
        end
      end
      SETTLE: begin
        // Give the UART a bounded window to raise busy after the write.
        seq_rd   = 1'b1;
        seq_addr = CON_ADDR;
        if (grant) begin
          if (uart_busy || settle_cnt == SETTLE_LAST) state_nxt  = DRAIN;
          else                                        settle_nxt = settle_cnt + 1'b1;
        end
      end
      DRAIN: begin
        seq_rd   = 1'b1;
        seq_addr = CON_ADDR;
        if (grant && !uart_busy) state_nxt = (count != '0) ? POLL : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus mux: CPU passes straight through; otherwise the sequencer request (zeros when idle).
  always_comb begin
    if (cpu_act) begin
      bus.bus_rd    = cpu_rd;
      bus.bus_wr    = cpu_wr;
      bus.bus_addr  = cpu_addr;
      bus.bus_wdata = cpu_wdata;
    end else begin
      bus.bus_rd    = seq_rd;
      bus.bus_wr    = seq_wr;
      bus.bus_addr  = seq_addr;
      bus.bus_wdata = seq_wdata;
    end
  end

`ifdef UART_TXSEQ_IRQ_EN
  // One-cycle pulse after the final DRAIN->IDLE transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tx_done_irq <= 1'b0;
    else        tx_done_irq <= (state == DRAIN) && (state_nxt == IDLE);
  end
`endif

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Testbench for uart_tx_sequencer: scoreboard of expected TXD writes,
// a combinational CON register model, and one task per scenario.
module tb_uart_tx_sequencer;

  localparam logic [31:0] TXD_ADDR   = 32'h4000_0018;
  localparam logic [31:0] CON_ADDR   = 32'h4000_0020;
  localparam logic [31:0] OTHER_ADDR = 32'h4000_0010;
  localparam logic [31:0] OTHER_DATA = 32'hCAFE_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready, busy;
  logic [2:0]  fifo_count;
  logic [31:0] con_val;
`ifdef UART_TXSEQ_IRQ_EN
  logic        tx_done_irq;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wr_log[$];
  int          rd_idx = 0;

  uart_tx_sequencer_if bif();

  uart_tx_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .bus        (bif),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .busy       (busy),
    .fifo_count (fifo_count)
`ifdef UART_TXSEQ_IRQ_EN
    ,
    .tx_done_irq(tx_done_irq)
`endif
  );

  always #5 clk = ~clk;

  // Peripheral model: CON returns con_val, any other read returns OTHER_DATA.
  assign bif.bus_rdata = !bif.bus_rd ? 32'h0 :
                         (bif.bus_addr == CON_ADDR) ? con_val : OTHER_DATA;

  // Capture every sequencer write to the TXD register.
  always @(negedge clk) begin
    if (reset && bif.bus_wr && !cpu_wr && bif.bus_addr == TXD_ADDR)
      wr_log.push_back(bif.bus_wdata);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit expect_written);
    s_valid = 1'b1;
    s_data  = b;
    if (expect_written) exp_q.push_back({24'h0, b});
    tick();
    s_valid = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++; if (bif.bus_rd !== 1'b0)    begin n_fail++; $display("FAIL reset bus_rd got %b want 0", bif.bus_rd); end
    n_checks++; if (bif.bus_wr !== 1'b0)    begin n_fail++; $display("FAIL reset bus_wr got %b want 0", bif.bus_wr); end
    n_checks++; if (bif.bus_addr !== 32'h0) begin n_fail++; $display("FAIL reset bus_addr got %h want 0", bif.bus_addr); end
    n_checks++; if (bif.bus_wdata !== 32'h0) begin n_fail++; $display("FAIL reset bus_wdata got %h want 0", bif.bus_wdata); end
    n_checks++; if (cpu_rdata !== 32'h0)    begin n_fail++; $display("FAIL reset cpu_rdata got %h want 0", cpu_rdata); end
    n_checks++; if (s_ready !== 1'b1)       begin n_fail++; $display("FAIL reset s_ready got %b want 1", s_ready); end
    n_checks++; if (fifo_count !== 3'd0)    begin n_fail++; $display("FAIL reset fifo_count got %0d want 0", fifo_count); end
    n_checks++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL reset busy got %b want 0", busy); end
  endtask

  task automatic test_single_byte;
    int n;
    logic [31:0] e, g;
    con_val = 32'h1;
    push_byte(8'hA5, 1'b1);
    n_checks++; if (fifo_count !== 3'd1 || bif.bus_rd !== 1'b0 || bif.bus_wr !== 1'b0)
      begin n_fail++; $display("FAIL single after_push count=%0d rd=%b wr=%b want 1/0/0", fifo_count, bif.bus_rd, bif.bus_wr); end
    tick();
    n_checks++; if (bif.bus_rd !== 1'b1 || bif.bus_addr !== CON_ADDR || bif.bus_wr !== 1'b0)
      begin n_fail++; $display("FAIL single poll rd=%b addr=%h wr=%b want 1/%h/0", bif.bus_rd, bif.bus_addr, bif.bus_wr, CON_ADDR); end
    tick();
    n_checks++; if (bif.bus_wr !== 1'b1 || bif.bus_addr !== TXD_ADDR || bif.bus_wdata !== 32'hA5)
      begin n_fail++; $display("FAIL single write wr=%b addr=%h wdata=%h want 1/%h/000000a5", bif.bus_wr, bif.bus_addr, bif.bus_wdata, TXD_ADDR); end
    tick();
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL single count_after got %0d want 0", fifo_count); end
    n = 0;
    while (busy !== 1'b0 && n < 100) begin tick(); n++; end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single idle_timeout busy=%b want 0", busy); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = (rd_idx < wr_log.size()) ? wr_log[rd_idx] : 32'hx;
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL single sb[%0d] got %h want %h", rd_idx, g, e); end
      rd_idx++;
    end
  endtask

  task automatic test_cpu_priority;
    int n;
    logic [31:0] e, g;
    con_val = 32'h1;
    push_byte(8'h3C, 1'b1);
    tick();
    n_checks++; if (bif.bus_rd !== 1'b1 || bif.bus_addr !== CON_ADDR)
      begin n_fail++; $display("FAIL cpu pre_poll rd=%b addr=%h", bif.bus_rd, bif.bus_addr); end
    cpu_rd = 1'b1; cpu_addr = OTHER_ADDR;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (bif.bus_addr !== OTHER_ADDR || bif.bus_rd !== 1'b1 || bif.bus_wr !== 1'b0 || cpu_rdata !== OTHER_DATA)
        begin n_fail++; $display("FAIL cpu pass[%0d] addr=%h rd=%b wr=%b rdata=%h want %h/1/0/%h", k, bif.bus_addr, bif.bus_rd, bif.bus_wr, cpu_rdata, OTHER_ADDR, OTHER_DATA); end
      tick();
    end
    cpu_rd = 1'b0; cpu_addr = 32'h0;
    #1;
    n_checks++; if (bif.bus_rd !== 1'b1 || bif.bus_addr !== CON_ADDR || bif.bus_wr !== 1'b0)
      begin n_fail++; $display("FAIL cpu still_poll rd=%b addr=%h wr=%b want 1/%h/0", bif.bus_rd, bif.bus_addr, bif.bus_wr, CON_ADDR); end
    tick();
    n_checks++; if (bif.bus_wr !== 1'b1 || bif.bus_wdata !== 32'h3C)
      begin n_fail++; $display("FAIL cpu delayed_write wr=%b wdata=%h want 1/0000003c", bif.bus_wr, bif.bus_wdata); end
    n = 0;
    while (busy !== 1'b0 && n < 100) begin tick(); n++; end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cpu idle_timeout busy=%b want 0", busy); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = (rd_idx < wr_log.size()) ? wr_log[rd_idx] : 32'hx;
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL cpu sb[%0d] got %h want %h", rd_idx, g, e); end
      rd_idx++;
    end
  endtask

  task automatic test_back_pressure;
    int n, wr0;
    logic [31:0] e, g;
    con_val = 32'h11;
    wr0 = wr_log.size();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (s_ready !== (i < 4))
        begin n_fail++; $display("FAIL bp s_ready[%0d] got %b want %b", i, s_ready, (i < 4)); end
      push_byte(8'hB0 + 8'(i), (i < 4));
    end
    repeat (3) tick();
    n_checks++; if (fifo_count !== 3'd4 || s_ready !== 1'b0 || wr_log.size() != wr0)
      begin n_fail++; $display("FAIL bp full count=%0d s_ready=%b writes=%0d want 4/0/%0d", fifo_count, s_ready, wr_log.size(), wr0); end
    con_val = 32'h1;
    n = 0;
    while (bif.bus_wr !== 1'b1 && n < 50) begin tick(); n++; end
    n_checks++; if (bif.bus_wr !== 1'b1 || s_ready !== 1'b0)
      begin n_fail++; $display("FAIL bp pop_cycle wr=%b s_ready=%b want 1/0", bif.bus_wr, s_ready); end
    tick();
    n_checks++; if (s_ready !== 1'b1 || fifo_count !== 3'd3)
      begin n_fail++; $display("FAIL bp after_pop s_ready=%b count=%0d want 1/3", s_ready, fifo_count); end
    n = 0;
    while (busy !== 1'b0 && n < 300) begin tick(); n++; end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp idle_timeout busy=%b want 0", busy); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = (rd_idx < wr_log.size()) ? wr_log[rd_idx] : 32'hx;
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL bp sb[%0d] got %h want %h", rd_idx, g, e); end
      rd_idx++;
    end
  endtask

  task automatic test_settle_timeout;
    int n, gap;
    logic [31:0] e, g;
    con_val = 32'h1;
    push_byte(8'hC1, 1'b1);
    push_byte(8'hC2, 1'b1);
    n = 0;
    while (bif.bus_wr !== 1'b1 && n < 50) begin tick(); n++; end
    n_checks++; if (bif.bus_wr !== 1'b1) begin n_fail++; $display("FAIL settle first_write wr=%b want 1", bif.bus_wr); end
    tick(); gap = 1;
    while (bif.bus_wr !== 1'b1 && gap < 50) begin tick(); gap++; end
    n_checks++; if (gap != 11) begin n_fail++; $display("FAIL settle write_gap got %0d want 11", gap); end
    n = 0;
    while (busy !== 1'b0 && n < 100) begin tick(); n++; end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL settle idle_timeout busy=%b want 0", busy); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = (rd_idx < wr_log.size()) ? wr_log[rd_idx] : 32'hx;
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL settle sb[%0d] got %h want %h", rd_idx, g, e); end
      rd_idx++;
    end
  endtask

  task automatic test_settle_busy;
    int n;
    logic [31:0] e, g;
    con_val = 32'h1;
    push_byte(8'h5A, 1'b1);
    n = 0;
    while (bif.bus_wr !== 1'b1 && n < 50) begin tick(); n++; end
    con_val = 32'h11;
    tick(); tick(); tick();
    n_checks++; if (busy !== 1'b1 || bif.bus_rd !== 1'b1 || bif.bus_addr !== CON_ADDR)
      begin n_fail++; $display("FAIL busyrise drain_wait busy=%b rd=%b addr=%h want 1/1/%h", busy, bif.bus_rd, bif.bus_addr, CON_ADDR); end
    con_val = 32'h1;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busyrise done busy=%b want 0", busy); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = (rd_idx < wr_log.size()) ? wr_log[rd_idx] : 32'hx;
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL busyrise sb[%0d] got %h want %h", rd_idx, g, e); end
      rd_idx++;
    end
  endtask

  task automatic test_tx_disabled;
    int n, wr0;
    logic [31:0] e, g;
    con_val = 32'h0;
    wr0 = wr_log.size();
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    repeat (20) tick();
    n_checks++; if (wr_log.size() != wr0 || bif.bus_rd !== 1'b1 || bif.bus_addr !== CON_ADDR || fifo_count !== 3'd2)
      begin n_fail++; $display("FAIL txdis stall writes=%0d rd=%b addr=%h count=%0d want %0d/1/%h/2", wr_log.size(), bif.bus_rd, bif.bus_addr, fifo_count, wr0, CON_ADDR); end
    con_val = 32'h1;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin tick(); n++; end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL txdis idle_timeout busy=%b want 0", busy); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = (rd_idx < wr_log.size()) ? wr_log[rd_idx] : 32'hx;
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL txdis sb[%0d] got %h want %h", rd_idx, g, e); end
      rd_idx++;
    end
  endtask

  task automatic test_reset_mid;
    int n, wr0;
    logic [31:0] e, g;
    con_val = 32'h1;
    push_byte(8'h77, 1'b1);
    push_byte(8'h88, 1'b0);
    n = 0;
    while (bif.bus_wr !== 1'b1 && n < 50) begin tick(); n++; end
    tick();
    #1 reset = 1'b0;
    #1;
    n_checks++; if (bif.bus_rd !== 1'b0 || bif.bus_wr !== 1'b0 || bif.bus_addr !== 32'h0 || bif.bus_wdata !== 32'h0 || cpu_rdata !== 32'h0)
      begin n_fail++; $display("FAIL midreset bus rd=%b wr=%b addr=%h wdata=%h rdata=%h want zeros", bif.bus_rd, bif.bus_wr, bif.bus_addr, bif.bus_wdata, cpu_rdata); end
    n_checks++; if (s_ready !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL midreset fifo s_ready=%b count=%0d busy=%b want 1/0/0", s_ready, fifo_count, busy); end
`ifdef UART_TXSEQ_IRQ_EN
    n_checks++; if (tx_done_irq !== 1'b0) begin n_fail++; $display("FAIL midreset irq got %b want 0", tx_done_irq); end
`endif
    @(negedge clk) reset = 1'b1;
    wr0 = wr_log.size();
    repeat (10) tick();
    n_checks++; if (busy !== 1'b0 || wr_log.size() != wr0)
      begin n_fail++; $display("FAIL midreset lost busy=%b writes=%0d want 0/%0d", busy, wr_log.size(), wr0); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = (rd_idx < wr_log.size()) ? wr_log[rd_idx] : 32'hx;
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL midreset sb[%0d] got %h want %h", rd_idx, g, e); end
      rd_idx++;
    end
  endtask

`ifdef UART_TXSEQ_IRQ_EN
  task automatic test_irq;
    int n, pulses;
    logic [31:0] e, g;
    con_val = 32'h1;
    pulses = 0;
    push_byte(8'h01, 1'b1);
    push_byte(8'h02, 1'b1);
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      if (tx_done_irq === 1'b1) pulses++;
      tick(); n++;
    end
    repeat (4) begin
      if (tx_done_irq === 1'b1) pulses++;
      tick();
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL irq pulses got %0d want 1", pulses); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = (rd_idx < wr_log.size()) ? wr_log[rd_idx] : 32'hx;
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL irq sb[%0d] got %h want %h", rd_idx, g, e); end
      rd_idx++;
    end
  endtask
`endif

  initial begin
    reset = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    s_valid = 1'b0; s_data = 8'h0; con_val = 32'h1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    tick();
    test_reset();
    test_single_byte();
    test_cpu_priority();
    test_back_pressure();
    test_settle_timeout();
    test_settle_busy();
    test_tx_disabled();
    test_reset_mid();
`ifdef UART_TXSEQ_IRQ_EN
    test_irq();
`endif
    n_checks++; if (wr_log.size() != rd_idx)
      begin n_fail++; $display("FAIL extra_writes got %0d want %0d", wr_log.size(), rd_idx); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
